// File: rtl/ctrl_seq.sv
// ctrl_seq: sequential control decoder with a run/halt sequencer.
// It decodes each valid instruction in RUN into datapath controls. It also
// holds the mode (bank-select) register and the sticky done (Ack) flag.
// Decode outputs are combinational from Instruction and the registered Mode.
module ctrl_seq #(
   parameter int             IW      = 9,
   parameter int             OPW     = 3,
   parameter int             SW      = 2,
   parameter logic [OPW-1:0] SET_OP  = 3'b110,
   parameter logic [OPW-1:0] HALT_OP = 3'b111
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          InstValid,
   input  logic [IW-1:0] Instruction,
   output logic          MemWrite,
   output logic          BranchEn,
   output logic          RegWrite,
   output logic          NextLFSR,
   output logic          RegOut1,
   output logic          RegOut2,
   output logic [1:0]    MemToReg,
   output logic [1:0]    RegDest,
   output logic [1:0]    ALUSrc,
   output logic [3:0]    ALUOp,
   output logic [SW-1:0] Mode,
   output logic          Busy,
   output logic          Ack,
   output logic          Illegal
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic       mem_write;
      logic       branch_en;
      logic       reg_write;
      logic       next_lfsr;
      logic       reg_out1;
      logic       reg_out2;
      logic [1:0] mem_to_reg;
      logic [1:0] reg_dest;
      logic [1:0] alu_src;
      logic [3:0] alu_op;
   } ctrl_t;

   state_t        r_state;
   logic [SW-1:0] r_mode;
   logic          r_ack;

   logic [OPW-1:0] w_op;
   logic [1:0]     w_mode_lo;
   logic           w_en;
   logic           w_is_set;
   logic           w_is_halt;
   logic           w_mode_rsvd;
   ctrl_t          w_ctrl;
   logic           w_illegal;

   assign w_op      = Instruction[IW-1 -: OPW];
   assign w_mode_lo = r_mode[1:0];
   assign w_en      = (r_state == RUN) && InstValid;
   assign w_is_set  = w_en && (w_op == SET_OP);
   assign w_is_halt = w_en && (w_op == HALT_OP);
   // Modes 4 and above exist only when SW > 2. With SW == 2 this is constant 0.
   assign w_mode_rsvd = (r_mode > SW'(3));

   // Sequencer: run/halt state, mode register and sticky Ack.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_mode  <= '0;
         r_ack   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (Start) begin
                  r_state <= RUN;
                  r_mode  <= '0;
                  r_ack   <= 1'b0;
               end
            end
            RUN: begin
               // Start is ignored here. HALT is the only way out besides Reset.
               if (w_is_halt) begin
                  r_state <= DONE;
                  r_ack   <= 1'b1;
               end else if (w_is_set) begin
                  r_mode <= Instruction[SW-1:0];
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Instruction decode: table lookup on opcode and mode. Without en this is a NOP.
   // NOTE: every signal gets a default before the case, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      w_ctrl    = '0;
      w_illegal = 1'b0;
      if (w_en && !w_is_set && !w_is_halt) begin
         if (w_mode_rsvd) begin
            w_illegal = 1'b1;
         end else begin
            case (w_op)
               OPW'(0): begin
                  case (w_mode_lo)
                     2'd0: begin // Load
                        w_ctrl.mem_to_reg = 2'b01;
                        w_ctrl.alu_src    = 2'b01;
                        w_ctrl.reg_write  = 1'b1;
                     end
                     2'd1: begin // Store
                        w_ctrl.mem_write = 1'b1;
                        w_ctrl.alu_src   = 2'b01;
                     end
                     2'd2: begin // Add
                        w_ctrl.reg_write = 1'b1;
                     end
                     default: begin // Sub
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.alu_op    = 4'b0001;
                     end
                  endcase
               end
               OPW'(1): begin
                  w_ctrl.alu_src   = 2'b01;
                  w_ctrl.reg_write = 1'b1;
                  case (w_mode_lo)
                     2'd0:    w_ctrl.alu_op = 4'b0010; // LSL
                     2'd1:    w_ctrl.alu_op = 4'b0011; // LSR
                     2'd2:    w_ctrl.alu_op = 4'b0100; // MovI
                     default: begin                    // setLFSR
                        w_ctrl.mem_to_reg = 2'b11;
                        w_ctrl.reg_dest   = 2'b01;
                        w_ctrl.alu_op     = 4'b0100;
                     end
                  endcase
               end
               OPW'(2): begin
                  case (w_mode_lo)
                     2'd0: begin // XOR into the register pair
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.reg_out1  = 1'b1;
                        w_ctrl.reg_out2  = 1'b1;
                        w_ctrl.alu_op    = 4'b0101;
                     end
                     2'd1: begin // Next: step the LFSR
                        w_ctrl.next_lfsr = 1'b1;
                        w_ctrl.alu_op    = 4'b0101;
                     end
                     2'd2: begin // XOR
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.alu_op    = 4'b0101;
                     end
                     default: begin // AND
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.alu_op    = 4'b0110;
                     end
                  endcase
               end
               OPW'(3): begin
                  case (w_mode_lo)
                     2'd0: begin // OR
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.alu_op    = 4'b0111;
                     end
                     2'd1: begin // setTap
                        w_ctrl.mem_to_reg = 2'b11;
                        w_ctrl.reg_dest   = 2'b10;
                        w_ctrl.reg_out1   = 1'b1;
                        w_ctrl.reg_write  = 1'b1;
                        w_ctrl.alu_op     = 4'b0111;
                     end
                     2'd2: begin // BGE
                        w_ctrl.branch_en = 1'b1;
                        w_ctrl.alu_op    = 4'b1000;
                     end
                     default: begin // BNE
                        w_ctrl.branch_en = 1'b1;
                        w_ctrl.alu_op    = 4'b1001;
                     end
                  endcase
               end
               OPW'(4): begin
                  case (w_mode_lo)
                     2'd0: begin // RXOR
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.reg_out1  = 1'b1;
                        w_ctrl.reg_out2  = 1'b1;
                        w_ctrl.alu_op    = 4'b1010;
                     end
                     2'd1: begin // BEQ
                        w_ctrl.branch_en = 1'b1;
                        w_ctrl.alu_op    = 4'b1011;
                     end
                     2'd2: begin // getTap
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.reg_out1  = 1'b1;
                        w_ctrl.reg_out2  = 1'b1;
                        w_ctrl.alu_src   = 2'b10;
                        w_ctrl.alu_op    = 4'b1100;
                     end
                     default: w_illegal = 1'b1; // op 4 / mode 3 is reserved
                  endcase
               end
               default: w_illegal = 1'b1; // op 5 and any other unused opcode
            endcase
         end
      end
   end

   assign MemWrite = w_ctrl.mem_write;
   assign BranchEn = w_ctrl.branch_en;
   assign RegWrite = w_ctrl.reg_write;
   assign NextLFSR = w_ctrl.next_lfsr;
   assign RegOut1  = w_ctrl.reg_out1;
   assign RegOut2  = w_ctrl.reg_out2;
   assign MemToReg = w_ctrl.mem_to_reg;
   assign RegDest  = w_ctrl.reg_dest;
   assign ALUSrc   = w_ctrl.alu_src;
   assign ALUOp    = w_ctrl.alu_op;
   assign Illegal  = w_illegal;
   assign Mode     = r_mode;
   assign Ack      = r_ack;
   assign Busy     = (r_state == RUN);

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Sequential, parametrised successor to the processor's combinational control decoder.
- The mode (bank-select) register is a real clocked register with asynchronous reset, not a latch.
- Adds a run/halt state machine: Start handshake, a sticky Ack and Busy, and an Illegal flag for reserved encodings.
- Sits between instruction ROM and datapath; drives program_counter, register file, ALU and data memory controls.

Parameters:
- IW, 9, instruction width.
- OPW, 3, opcode width; opcode = Instruction[IW-1 -: OPW].
- SW, 2, mode register width; SET loads Instruction[SW-1:0].
- SET_OP, 3'b110, opcode that loads Mode.
- HALT_OP, 3'b111, opcode that ends the program.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Start  in  1  one-cycle pulse: begin or restart a program.
- InstValid  in  1  Instruction is valid this cycle.
- Instruction  in  IW  machine code.
- MemWrite, BranchEn, RegWrite, NextLFSR, RegOut1, RegOut2  out  1 each  datapath controls.
- MemToReg, RegDest, ALUSrc  out  2 each  mux selects.
- ALUOp  out  4  ALU operation.
- Mode  out  SW  current mode register.
- Busy  out  1  state == RUN.
- Ack  out  1  sticky "done w/ program".
- Illegal  out  1  reserved encoding decoded this cycle.

Behaviour:
- Reset (asynchronous): state=IDLE, Mode=0, Ack=0. All decode outputs are 0 during and after reset until RUN.
- States: IDLE, RUN, DONE.
  - IDLE: Start -> RUN.
  - RUN: InstValid with opcode HALT_OP -> DONE.
  - DONE: Start -> RUN.
- Decode enable: en = (state==RUN) && InstValid. When en=0, every decode output is 0 (NOP, ALUOp=0000).
- Latency: decode outputs are combinational from Instruction and the registered Mode; no added cycle.
- SET (en, opcode==SET_OP): decode outputs are 0. Mode <= Instruction[SW-1:0] at the next edge, so the new mode applies from the following instruction.
- HALT (en, opcode==HALT_OP): decode outputs are 0. At the next edge, state becomes DONE and Ack=1. Ack holds until Start or Reset.
- Start in RUN is ignored. Start in IDLE or DONE clears Ack and Mode at the edge; RUN begins the next cycle.
- Decode table: op/mode -> asserted signals. Unlisted signals are 0; ALUOp is 0000 unless given.
  - 0/0 Load: MemToReg=01, ALUSrc=01, RegWrite.
  - 0/1 Store: MemWrite, ALUSrc=01.
  - 0/2 Add: RegWrite.
  - 0/3 Sub: RegWrite, ALUOp=0001.
  - 1/0 LSL: ALUSrc=01, RegWrite, ALUOp=0010.
  - 1/1 LSR: ALUSrc=01, RegWrite, ALUOp=0011.
  - 1/2 MovI: ALUSrc=01, RegWrite, ALUOp=0100.
  - 1/3 setLFSR: MemToReg=11, RegDest=01, ALUSrc=01, RegWrite, ALUOp=0100.
  - 2/0 XOR: RegWrite, RegOut1, RegOut2, ALUOp=0101.
  - 2/1 Next: NextLFSR, ALUOp=0101.
  - 2/2 XOR: RegWrite, ALUOp=0101.
  - 2/3 AND: RegWrite, ALUOp=0110.
  - 3/0 OR: RegWrite, ALUOp=0111.
  - 3/1 setTap: MemToReg=11, RegDest=10, RegOut1, RegWrite, ALUOp=0111.
  - 3/2 BGE: BranchEn, ALUOp=1000.
  - 3/3 BNE: BranchEn, ALUOp=1001.
  - 4/0 RXOR: RegWrite, RegOut1, RegOut2, ALUOp=1010.
  - 4/1 BEQ: BranchEn, ALUOp=1011.
  - 4/2 getTap: RegWrite, RegOut1, RegOut2, ALUSrc=10, ALUOp=1100.
- Reserved encodings: op 4 with mode 3, op 5, any other opcode not SET_OP/HALT_OP/table, and any mode >= 4 (when SW>2).
  - Under en, a reserved encoding decodes as NOP with Illegal=1 for that cycle.
  - No state change; Mode is unchanged.
- Simultaneous events: a HALT under en always wins the state transition; Start cannot coincide with en because Start is ignored in RUN.
- Reset mid-RUN aborts immediately (asynchronously); outputs drop to 0.

Test Plan:
- Reset, Start, then SET 9'b110_000_010 followed by 9'b011_000_000 -> during SET all outputs 0; next cycle Mode=2, BranchEn=1, ALUOp=1000, RegWrite=0.
- SET mode 1, then 9'b011_xxx_xxx -> MemToReg=11, RegDest=10, RegOut1=1, RegWrite=1, ALUOp=0111.
- RUN with InstValid=0 over a Load encoding -> all decode outputs 0, Illegal=0.
- In RUN, mode 3 with op 4, then op 5 -> Illegal=1 each cycle, all controls 0, Mode stays 3, Busy=1.
- HALT 9'b111_000_000 -> next cycle Ack=1, Busy=0, held for 10 cycles; Start -> Ack=0, Mode=0, Busy=1.
- Assert Reset asynchronously mid-cycle during a Store -> MemWrite drops without waiting for a Clk edge; after release, state=IDLE, Mode=0, Ack=0.
